// File: rtl/symbol_decode_arbiter.sv
// Round-robin arbiter sharing one 1-cycle registered symbol-decode table
// among NUM_REQ requesters. Each requester owns a one-entry response buffer;
// a requester with a lookup in flight or an unconsumed response is not
// granted again, so there is never more than one lookup per requester.
module symbol_decode_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CODE_W  = 8,
  parameter int SYM_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*CODE_W-1:0] req_code,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*SYM_W-1:0]  rsp_symbol,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      dec_en,
  output logic [CODE_W-1:0]         dec_code,
  input  logic [SYM_W-1:0]          dec_symbol,
  input  logic                      dec_valid,
  output logic [15:0]               lookup_count,
  output logic                      err_unexpected,
  output logic                      err_missing
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*SYM_W-1:0] rsp_symbol_q, rsp_symbol_d;
  logic                     infl_v_q, infl_v_d;
  logic [ID_W-1:0]          infl_id_q, infl_id_d;
  logic [ID_W-1:0]          rr_q, rr_d;
  logic [15:0]              lookup_count_q, lookup_count_d;
  logic                     err_missing_q, err_missing_d;
  logic                     err_unexpected_q, err_unexpected_d;

  logic [NUM_REQ-1:0]       busy;
  logic [NUM_REQ-1:0]       elig;
  logic                     gnt_v;
  logic [ID_W-1:0]          gnt_id;

  // Busy covers the in-flight cycle and the buffered-response cycle(s).
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    busy = rsp_valid_q;
    if (infl_v_q) busy[infl_id_q] = 1'b1;
  end

  // Eligible requesters; reset_n gates grants so combinational outputs are
  // quiet while reset is held.
  assign elig = req_valid & ~busy & {NUM_REQ{arb_en & reset_n}};

  // Round-robin search starting at the rr pointer; first eligible wins.
  always_comb begin
    int idx;
    gnt_v  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!gnt_v && elig[idx]) begin
        gnt_v  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  // Next state: response pop/fill, error detection, in-flight tracking.
  always_comb begin
    // rsp_ready is only honoured where a response is actually held.
    rsp_valid_d      = rsp_valid_q & ~rsp_ready;
    rsp_symbol_d     = rsp_symbol_q;
    err_missing_d    = err_missing_q;
    err_unexpected_d = err_unexpected_q;
    if (infl_v_q) begin
      if (dec_valid) begin
        // The target buffer was empty at grant time and nobody else writes
        // it, so filling after the pop cannot overwrite a live response.
        rsp_valid_d[infl_id_q]                  = 1'b1;
        rsp_symbol_d[infl_id_q*SYM_W +: SYM_W] = dec_symbol;
      end else begin
        err_missing_d = 1'b1;
      end
    end else if (dec_valid) begin
      err_unexpected_d = 1'b1;
    end
    infl_v_d       = gnt_v;
    infl_id_d      = gnt_v ? gnt_id : infl_id_q;
    rr_d           = rr_q;
    if (gnt_v) rr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    lookup_count_d = lookup_count_q + 16'(gnt_v);
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q      <= '0;
      // NOTE: the symbol buffers are reset as well because they are visible
      // outputs; data-only storage would normally be left unreset.
      rsp_symbol_q     <= '0;
      infl_v_q         <= 1'b0;
      infl_id_q        <= '0;
      rr_q             <= '0;
      lookup_count_q   <= '0;
      err_missing_q    <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      rsp_valid_q      <= rsp_valid_d;
      rsp_symbol_q     <= rsp_symbol_d;
      infl_v_q         <= infl_v_d;
      infl_id_q        <= infl_id_d;
      rr_q             <= rr_d;
      lookup_count_q   <= lookup_count_d;
      err_missing_q    <= err_missing_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  // Outputs: grant handshake and decoder strobe are combinational.
  always_comb begin
    req_ready      = gnt_v ? (NUM_REQ'(1) << gnt_id) : '0;
    dec_en         = gnt_v;
    dec_code       = gnt_v ? req_code[gnt_id*CODE_W +: CODE_W] : '0;
    rsp_valid      = rsp_valid_q;
    rsp_symbol     = rsp_symbol_q;
    lookup_count   = lookup_count_q;
    err_missing    = err_missing_q;
    err_unexpected = err_unexpected_q;
  end

endmodule

// File: tb/tb_symbol_decode_arbiter.sv
// Bench for symbol_decode_arbiter: behavioural decode table, per-requester
// expectation queues filled at grant and drained at response handshake.
module tb_symbol_decode_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CODE_W  = 8;
  localparam int SYM_W   = 16;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      arb_en = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*CODE_W-1:0] req_code = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*SYM_W-1:0]  rsp_symbol;
  logic [NUM_REQ-1:0]        rsp_ready = '0;
  logic                      dec_en;
  logic [CODE_W-1:0]         dec_code;
  logic [SYM_W-1:0]          dec_symbol = '0;
  logic                      dec_valid = 1'b0;
  logic [15:0]               lookup_count;
  logic                      err_unexpected;
  logic                      err_missing;

  logic suppress = 1'b0;
  logic spur = 1'b0;

  int total = 0;
  int bad = 0;

  logic [SYM_W-1:0] exp_q [NUM_REQ][$];
  int               grant_log [$];
  logic             pend_v = 1'b0;
  int               pend_id = 0;
  logic [SYM_W-1:0] pend_sym = '0;

  always #5 clk = ~clk;

  symbol_decode_arbiter #(.NUM_REQ(NUM_REQ), .CODE_W(CODE_W), .SYM_W(SYM_W)) dut (
    .clk(clk), .reset_n(reset_n), .arb_en(arb_en),
    .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_symbol(rsp_symbol), .rsp_ready(rsp_ready),
    .dec_en(dec_en), .dec_code(dec_code), .dec_symbol(dec_symbol),
    .dec_valid(dec_valid), .lookup_count(lookup_count),
    .err_unexpected(err_unexpected), .err_missing(err_missing)
  );

  function automatic logic [SYM_W-1:0] tbl(input logic [CODE_W-1:0] c);
    if (c == 8'h05) tbl = 16'hBEEF;
    else            tbl = {c ^ 8'h3C, ~c};
  endfunction

  // Decoder model: registered one-cycle lookup with fault injection.
  always @(posedge clk) begin
    dec_valid  <= (dec_en & ~suppress) | spur;
    dec_symbol <= tbl(dec_code);
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
      pend_v = 1'b0;
    end else begin
      if (pend_v && dec_valid) exp_q[pend_id].push_back(pend_sym);
      pend_v = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          pend_v   = 1'b1;
          pend_id  = i;
          pend_sym = tbl(req_code[i*CODE_W +: CODE_W]);
          grant_log.push_back(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          total++;
          if (exp_q[i].size() == 0) begin
            bad++;
            $display("FAIL rsp_extra_q%0d got=%h exp=none", i, rsp_symbol[i*SYM_W +: SYM_W]);
          end else begin
            logic [SYM_W-1:0] e;
            e = exp_q[i].pop_front();
            if (rsp_symbol[i*SYM_W +: SYM_W] !== e) begin
              bad++;
              $display("FAIL rsp_sym_q%0d got=%h exp=%h", i, rsp_symbol[i*SYM_W +: SYM_W], e);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0; req_valid = '0; rsp_ready = '0; arb_en = 1'b0;
    suppress = 1'b0; spur = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    step();
    req_valid = '0; rsp_ready = '1;
    repeat (4) step();
    for (int i = 0; i < NUM_REQ; i++) begin
      total++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL drain_q%0d got=%0d pending exp=0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '1; arb_en = 1'b1; req_code = 32'h4433_2211;
    sample();
    total++;
    if ({req_ready, dec_en, dec_code} !== '0) begin
      bad++;
      $display("FAIL reset_comb got=%h/%b/%h exp=0", req_ready, dec_en, dec_code);
    end
    total++;
    if ({rsp_valid, rsp_symbol, lookup_count, err_unexpected, err_missing} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h/%h/%h/%b%b exp=0", rsp_valid, rsp_symbol,
               lookup_count, err_unexpected, err_missing);
    end
    step();
    reset_n = 1'b1; req_valid = '0; arb_en = 1'b0;
  endtask

  task automatic test_reset_mid_lookup();
    step();
    arb_en = 1'b1; req_valid = 4'b0001; req_code = 32'h0000_0012; rsp_ready = '1;
    sample();
    total++;
    if (req_ready !== 4'b0001 || dec_code !== 8'h12) begin
      bad++;
      $display("FAIL mid_grant got=%b/%h exp=0001/12", req_ready, dec_code);
    end
    step();
    req_valid = '0; reset_n = 1'b0;
    sample();
    total++;
    if (rsp_valid !== '0 || lookup_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_in_reset got=%b/%0d exp=0/0", rsp_valid, lookup_count);
    end
    step();
    step();
    reset_n = 1'b1;
    repeat (4) step();
    sample();
    total++;
    if (rsp_valid !== '0 || lookup_count !== 16'd0 || {err_unexpected, err_missing} !== 2'b00) begin
      bad++;
      $display("FAIL mid_after got=%b/%0d/%b%b exp=0/0/00", rsp_valid, lookup_count,
               err_unexpected, err_missing);
    end
  endtask

  task automatic test_single();
    step();
    arb_en = 1'b1; req_valid = 4'b0010; req_code = 32'h0000_0500; rsp_ready = '0;
    sample();
    total++;
    if (req_ready !== 4'b0010 || dec_en !== 1'b1 || dec_code !== 8'h05) begin
      bad++;
      $display("FAIL single_grant got=%b/%b/%h exp=0010/1/05", req_ready, dec_en, dec_code);
    end
    step();
    req_valid = '0;
    sample();
    total++;
    if (rsp_valid !== '0) begin
      bad++;
      $display("FAIL single_early got=%b exp=0000", rsp_valid);
    end
    step();
    sample();
    total++;
    if (rsp_valid !== 4'b0010 || rsp_symbol[31:16] !== 16'hBEEF || lookup_count !== 16'd1) begin
      bad++;
      $display("FAIL single_rsp got=%b/%h/%0d exp=0010/beef/1", rsp_valid, rsp_symbol[31:16], lookup_count);
    end
    step();
    rsp_ready = 4'b0010;
    sample();
    step();
    rsp_ready = '0;
    sample();
    total++;
    if (rsp_valid !== '0 || rsp_symbol[31:16] !== 16'hBEEF) begin
      bad++;
      $display("FAIL single_pop got=%b/%h exp=0000/beef", rsp_valid, rsp_symbol[31:16]);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    grant_log.delete();
    arb_en = 1'b1; rsp_ready = '1;
    for (int c = 0; c < 8; c++) begin
      step();
      req_valid = '1;
      req_code = $urandom;
    end
    drain();
    total++;
    if (grant_log.size() != 8) begin
      bad++;
      $display("FAIL rr_count got=%0d exp=8", grant_log.size());
    end
    for (int c = 0; c < grant_log.size() && c < 8; c++) begin
      total++;
      if (grant_log[c] != c % NUM_REQ) begin
        bad++;
        $display("FAIL rr_order[%0d] got=%0d exp=%0d", c, grant_log[c], c % NUM_REQ);
      end
    end
    total++;
    if (lookup_count !== 16'd8) begin
      bad++;
      $display("FAIL rr_lookup_count got=%0d exp=8", lookup_count);
    end
  endtask

  task automatic test_held_response();
    int exp_order [13] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1, 2};
    do_reset();
    grant_log.delete();
    arb_en = 1'b1; rsp_ready = 4'b1011;
    for (int c = 0; c < 12; c++) begin
      step();
      req_valid = '1;
      req_code = $urandom;
    end
    step();
    req_valid = 4'b0100; rsp_ready = '1;
    sample();
    total++;
    if (req_ready !== '0) begin
      bad++;
      $display("FAIL held_pop_cycle got=%b exp=0000", req_ready);
    end
    step();
    sample();
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL held_regrant got=%b exp=0100", req_ready);
    end
    drain();
    total++;
    if (grant_log.size() != 13) begin
      bad++;
      $display("FAIL held_count got=%0d exp=13", grant_log.size());
    end
    for (int c = 0; c < grant_log.size() && c < 13; c++) begin
      total++;
      if (grant_log[c] != exp_order[c]) begin
        bad++;
        $display("FAIL held_order[%0d] got=%0d exp=%0d", c, grant_log[c], exp_order[c]);
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    arb_en = 1'b1; rsp_ready = '1;
    step();
    req_valid = 4'b1000; req_code = 32'h4000_0000; suppress = 1'b1;
    sample();
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL err_grant got=%b exp=1000", req_ready);
    end
    step();
    req_valid = '0; suppress = 1'b0;
    step();
    sample();
    total++;
    if (err_missing !== 1'b1 || err_unexpected !== 1'b0 || rsp_valid !== '0) begin
      bad++;
      $display("FAIL err_missing got=%b/%b/%b exp=1/0/0000", err_missing, err_unexpected, rsp_valid);
    end
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    sample();
    total++;
    if (err_unexpected !== 1'b1 || rsp_valid !== '0) begin
      bad++;
      $display("FAIL err_unexpected got=%b/%b exp=1/0000", err_unexpected, rsp_valid);
    end
    step();
    req_valid = 4'b0001; req_code = 32'h0000_0077;
    step();
    req_valid = '0;
    step();
    sample();
    total++;
    if (rsp_valid !== 4'b0001 || {err_unexpected, err_missing} !== 2'b11) begin
      bad++;
      $display("FAIL err_sticky got=%b/%b%b exp=0001/11", rsp_valid, err_unexpected, err_missing);
    end
    drain();
    do_reset();
    sample();
    total++;
    if ({err_unexpected, err_missing} !== 2'b00) begin
      bad++;
      $display("FAIL err_clear got=%b%b exp=00", err_unexpected, err_missing);
    end
  endtask

  task automatic test_arb_en();
    do_reset();
    step();
    arb_en = 1'b1; req_valid = '1; rsp_ready = '1; req_code = $urandom;
    sample();
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL arb_first got=%b exp=0001", req_ready);
    end
    for (int c = 1; c <= 5; c++) begin
      step();
      arb_en = 1'b0;
      sample();
      total++;
      if (req_ready !== '0 || dec_en !== 1'b0) begin
        bad++;
        $display("FAIL arb_off_c%0d got=%b/%b exp=0000/0", c, req_ready, dec_en);
      end
      if (c >= 2) begin
        total++;
        if (lookup_count !== 16'd1) begin
          bad++;
          $display("FAIL arb_frozen_c%0d got=%0d exp=1", c, lookup_count);
        end
      end
      if (c == 2) begin
        total++;
        if (rsp_valid !== 4'b0001) begin
          bad++;
          $display("FAIL arb_inflight got=%b exp=0001", rsp_valid);
        end
      end
    end
    step();
    arb_en = 1'b1;
    sample();
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL arb_resume got=%b exp=0010", req_ready);
    end
    drain();
    total++;
    if (lookup_count !== 16'd2) begin
      bad++;
      $display("FAIL arb_count got=%0d exp=2", lookup_count);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_lookup();
    test_single();
    test_round_robin();
    test_held_response();
    test_errors();
    test_arb_en();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
